// File: rtl/accum_cpu_pkg.sv
// Shared definitions for the accumulator CPU.
//   OPC_W    : opcode field width (top bits of every instruction word)
//   opcode_e : 8-entry instruction set
//   state_e  : sequencer states
package accum_cpu_pkg;

   localparam int unsigned OPC_W = 3;

   typedef enum logic [OPC_W-1:0] {
      OP_ADD   = 3'd0,
      OP_NAND  = 3'd1,
      OP_SHIFT = 3'd2,
      OP_LT    = 3'd3,
      OP_BZ    = 3'd4,
      OP_CP2W  = 3'd5,
      OP_CPFW  = 3'd6,
      OP_MUL   = 3'd7
   } opcode_e;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StInd,
      StOper,
      StExec,
      StStore,
      StHalt
   } state_e;

endpackage

// File: rtl/accum_cpu_alu.sv
// Combinational EXEC datapath: computes the next W from opcode, W and operand M.
// Optional feature macro: ACCUM_CPU_MUL_EN builds the half-width multiplier for OP_MUL;
// without it OP_MUL leaves W unchanged.
//   opcode : decoded instruction opcode
//   w      : current working register
//   m      : memory operand
//   w_next : new working register value (unchanged for BZ/CPFW)
module accum_cpu_alu
   import accum_cpu_pkg::*;
#(
   parameter int unsigned DATA_W = 16
) (
   input  opcode_e           opcode,
   input  logic [DATA_W-1:0] w,
   input  logic [DATA_W-1:0] m,
   output logic [DATA_W-1:0] w_next
);

   // Operand thresholds for the two shift directions.
   localparam logic [DATA_W-1:0] SHR_LIM = DATA_W'(DATA_W);
   localparam logic [DATA_W:0]   SHL_LIM = (DATA_W+1)'(2 * DATA_W);

`ifdef ACCUM_CPU_MUL_EN
   localparam int unsigned H = DATA_W / 2;
`endif

   always_comb begin
      w_next = w;
      unique case (opcode)
         OP_ADD:   w_next = w + m;
         OP_NAND:  w_next = ~(w & m);
         OP_SHIFT: begin
            if (m < SHR_LIM) begin
               w_next = w >> m;
            end else if ({1'b0, m} < SHL_LIM) begin
               w_next = w << (m - SHR_LIM);
            end else begin
               w_next = '0;
            end
         end
         OP_LT:    w_next = {{(DATA_W-1){1'b0}}, (w < m)};
         OP_CP2W:  w_next = m;
`ifdef ACCUM_CPU_MUL_EN
         OP_MUL:   w_next = DATA_W'(w[H-1:0]) * DATA_W'(m[H-1:0]);
`endif
         default:  w_next = w;
      endcase
   end

endmodule

// File: rtl/accum_cpu_pro.sv
// Multi-cycle accumulator CPU with a single req/ack memory port shared by
// instruction fetch, indirect pointer read, operand read and store.
// Optional feature macro: ACCUM_CPU_MUL_EN (enables OP_MUL in accum_cpu_alu).
//   clk, rst           : clock, synchronous active-high reset
//   mem_req/we/addr/wdata : memory request, held until mem_ack
//   mem_ack, mem_rdata : request accepted; read data valid in the ack cycle
//   pCounter           : address of the current instruction
//   instr_done         : one-cycle retire strobe
//   halted             : CPU stopped on a taken self-branch
module accum_cpu_pro
   import accum_cpu_pkg::*;
#(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ADDR_W  = 13,
   parameter int unsigned IND_PTR = 4
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] pCounter,
   output logic              instr_done,
   output logic              halted
);

   state_e            state_q;
   opcode_e           opcode_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] ea_q;
   logic [DATA_W-1:0] w_q;
   logic [DATA_W-1:0] m_q;
   logic [DATA_W-1:0] alu_w;

   opcode_e fetch_op;
   logic    fetch_a_zero;
   logic    bz_taken;

   assign fetch_op     = opcode_e'(mem_rdata[DATA_W-1 -: OPC_W]);
   assign fetch_a_zero = (mem_rdata[DATA_W-OPC_W-1:0] == '0);
   assign bz_taken     = (opcode_q == OP_BZ) && (w_q == '0);

   accum_cpu_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .opcode (opcode_q),
      .w      (w_q),
      .m      (m_q),
      .w_next (alu_w)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         opcode_q <= OP_ADD;
         pc_q     <= '0;
         ea_q     <= '0;
         w_q      <= '0;
         m_q      <= '0;
      end else begin
         unique case (state_q)
            StIdle: state_q <= StFetch;
            StFetch: begin
               if (mem_ack) begin
                  opcode_q <= fetch_op;
                  // Direct address; overwritten by the pointer when A == 0.
                  ea_q     <= mem_rdata[ADDR_W-1:0];
                  if (fetch_a_zero)           state_q <= StInd;
                  else if (fetch_op == OP_CPFW) state_q <= StStore;
                  else                        state_q <= StOper;
               end
            end
            StInd: begin
               if (mem_ack) begin
                  ea_q    <= mem_rdata[ADDR_W-1:0];
                  state_q <= (opcode_q == OP_CPFW) ? StStore : StOper;
               end
            end
            StOper: begin
               if (mem_ack) begin
                  m_q     <= mem_rdata;
                  state_q <= StExec;
               end
            end
            StExec: begin
               w_q <= alu_w;
               if (bz_taken) begin
                  pc_q    <= m_q[ADDR_W-1:0];
                  state_q <= (m_q[ADDR_W-1:0] == pc_q) ? StHalt : StFetch;
               end else begin
                  pc_q    <= pc_q + ADDR_W'(1);
                  state_q <= StFetch;
               end
            end
            StStore: begin
               if (mem_ack) begin
                  pc_q    <= pc_q + ADDR_W'(1);
                  state_q <= StFetch;
               end
            end
            StHalt:  state_q <= StHalt;
            default: state_q <= StIdle;
         endcase
      end
   end

   // Request signals depend only on registered state, so they hold steady through waits.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      unique case (state_q)
         StFetch: begin
            mem_req  = 1'b1;
            mem_addr = pc_q;
         end
         StInd: begin
            mem_req  = 1'b1;
            mem_addr = ADDR_W'(IND_PTR);
         end
         StOper: begin
            mem_req  = 1'b1;
            mem_addr = ea_q;
         end
         StStore: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ea_q;
            mem_wdata = w_q;
         end
         default: ;
      endcase
   end

   assign instr_done = (state_q == StExec) || ((state_q == StStore) && mem_ack);
   assign halted     = (state_q == StHalt);
   assign pCounter   = pc_q;

endmodule

// File: tb/tb_accum_cpu_pro.sv
module tb_accum_cpu_pro;

   localparam int IND = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req;
   logic        mem_we;
   logic [12:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [12:0] pCounter;
   logic        instr_done;
   logic        halted;

   accum_cpu_pro dut (
      .clk        (clk),
      .rst        (rst),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .pCounter   (pCounter),
      .instr_done (instr_done),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("%s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- memory responder ----------------
   logic [15:0] mem     [0:8191];
   logic [15:0] ref_mem [0:8191];
   int          cnt = 0;
   int          cur_wait = 0;
   int          wmode = 0;     // <0: random 0..2 per request, else fixed wait
   logic        stall = 1'b0;
   int          log_q[$];
   logic [29:0] hold_sig;

   function automatic int pick_wait();
      return (wmode < 0) ? int'($urandom_range(0, 2)) : wmode;
   endfunction

   assign mem_ack   = mem_req && !stall && (cnt >= cur_wait);
   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (rst || !mem_req || mem_ack) begin
         cnt <= 0;
         if (rst || mem_ack) cur_wait <= pick_wait();
      end else begin
         cnt <= cnt + 1;
      end
   end

   always @(negedge clk) begin
      #1;
      if (!rst && mem_req) begin
         if (cnt == 0) hold_sig = {mem_we, mem_addr, mem_wdata};
         else check("hold", 32'({mem_we, mem_addr, mem_wdata}), 32'(hold_sig));
         if (mem_ack) begin
            log_q.push_back(int'({mem_we, mem_addr}));
            if (mem_we) mem[mem_addr] = mem_wdata;
         end
      end
   end

   // ---------------- reference model (ISA level) ----------------
   int exp_log[$];
   int exp_pc, exp_w, exp_cyc, exp_halt;

   task automatic model(input int n);
      int pc, w, m, ea, op, a, k, extra, tgt;
      pc = 0; w = 0; k = 0;
      exp_log.delete(); exp_cyc = 0; exp_halt = 0;
      while (k < n && exp_halt == 0) begin
         op = int'(ref_mem[pc]) / 8192;
         a  = int'(ref_mem[pc]) % 8192;
         exp_log.push_back(pc);
         ea = a; extra = 0;
         if (a == 0) begin
            exp_log.push_back(IND);
            ea = int'(ref_mem[IND]) % 8192;
            extra = 1;
         end
         if (op == 6) begin
            exp_log.push_back(8192 + ea);
            ref_mem[ea] = 16'(w);
            pc = (pc + 1) % 8192;
            exp_cyc += 2 + extra;
         end else begin
            exp_log.push_back(ea);
            m = int'(ref_mem[ea]);
            exp_cyc += 3 + extra;
            case (op)
               0: w = (w + m) % 65536;
               1: w = 65535 - (w & m);
               2: w = (m < 16) ? (w >> m) : (m < 32) ? ((w << (m - 16)) % 65536) : 0;
               3: w = (w < m) ? 1 : 0;
               5: w = m;
`ifdef ACCUM_CPU_MUL_EN
               7: w = (w % 256) * (m % 256);
`endif
               default: ;
            endcase
            if (op == 4 && w == 0) begin
               tgt = m % 8192;
               if (tgt == pc) exp_halt = 1;
               pc = tgt;
            end else begin
               pc = (pc + 1) % 8192;
            end
         end
         k++;
      end
      exp_pc = pc; exp_w = w;
   endtask

   function automatic logic [15:0] ins(input int op, input int a);
      return 16'((op << 13) | a);
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'h0;
   endtask

   // Prologue: W=0, then jump to 8 so programs stay clear of the pointer cell.
   task automatic prologue();
      mem[60] = 16'h0;
      mem[61] = 16'd8;
      mem[0]  = ins(5, 60);
      mem[1]  = ins(4, 61);
   endtask

   // Reset, run n instructions, compare against the model.
   task automatic run(input string tag, input int n, input int wm);
      int retired, cyc, mm;
      ref_mem = mem;
      model(n);
      wmode = wm;
      stall = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      log_q.delete();
      rst = 1'b0;
      retired = 0; cyc = 0;
      while (retired < n && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (instr_done) retired++;
      end
      @(negedge clk);
      check({tag, "_retired"}, retired, n);
      if (wm >= 0) check({tag, "_cycles"}, cyc, exp_cyc + exp_log.size() * wm);
      check({tag, "_pc"}, 32'(pCounter), exp_pc);
      check({tag, "_halted"}, 32'(halted), exp_halt);
      mm = -1;
      for (int i = exp_log.size() - 1; i >= 0; i--)
         if (i >= log_q.size() || log_q[i] != exp_log[i]) mm = i;
      check({tag, "_access_seq"}, mm, -1);
   endtask

   initial begin
      int n_mis, any_req;
      int ops[7] = '{0, 1, 2, 3, 5, 6, 7};
      rst = 1'b1;
      for (int i = 0; i < 8192; i++) mem[i] = 16'h0;
      repeat (3) @(negedge clk);

      // Reset state.
      check("rst_req", 32'(mem_req), 0);
      check("rst_we", 32'(mem_we), 0);
      check("rst_addr", 32'(mem_addr), 0);
      check("rst_wdata", 32'(mem_wdata), 0);
      check("rst_pc", 32'(pCounter), 0);
      check("rst_done", 32'(instr_done), 0);
      check("rst_halted", 32'(halted), 0);

      // CP2W 10 ; ADD 11 ; CPfW 12, zero-wait.
      clear_mem();
      mem[0] = ins(5, 10); mem[1] = ins(0, 11); mem[2] = ins(6, 12);
      mem[10] = 16'd7; mem[11] = 16'd5;
      run("prog0", 3, 0);
      check("prog0_cyc8", exp_cyc, 8);
      check("prog0_mem12", 32'(mem[12]), 12);

      // W cleared by reset: store W first thing.
      mem[0] = ins(6, 13); mem[13] = 16'hBEEF;
      run("wrst", 1, 0);
      check("wrst_mem13", 32'(mem[13]), 0);

      // Reset mid-OPER with ack stalled.
      rst = 1'b1; wmode = 0; stall = 1'b0;
      clear_mem();
      mem[0] = ins(5, 10); mem[10] = 16'h55;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("mo_fetch", 32'({mem_req, mem_addr}), 32'({1'b1, 13'd0}));
      @(negedge clk);
      stall = 1'b1;
      check("mo_oper", 32'({mem_req, mem_we, mem_addr}), 32'({2'b10, 13'd10}));
      @(negedge clk);
      check("mo_stalled", 32'({mem_req, instr_done}), 32'(2'b10));
      rst = 1'b1;
      @(negedge clk);
      check("mo_rst_req", 32'(mem_req), 0);
      check("mo_rst_pc", 32'(pCounter), 0);
      check("mo_rst_addr", 32'(mem_addr), 0);
      rst = 1'b0; stall = 1'b0;
      @(negedge clk);
      check("mo_refetch", 32'({mem_req, mem_we, mem_addr}), 32'({2'b10, 13'd0}));

      // Same program with 3 wait states per request.
      clear_mem();
      mem[0] = ins(5, 10); mem[1] = ins(0, 11); mem[2] = ins(6, 12);
      mem[10] = 16'd7; mem[11] = 16'd5;
      run("prog3w", 3, 3);
      check("prog3w_mem12", 32'(mem[12]), 12);

      // Indirect operand: CP2W 0 via pointer at 4 -> 20.
      clear_mem();
      mem[0] = ins(5, 0); mem[1] = ins(6, 30);
      mem[4] = 16'd20; mem[20] = 16'h1234;
      run("ind", 2, 1);
      check("ind_w", 32'(mem[30]), 32'h1234);

      // SHIFT / LT / MUL.
      clear_mem(); prologue();
      mem[40] = 16'h00F0; mem[41] = 16'd4; mem[42] = 16'd20; mem[43] = 16'd40;
      mem[44] = 16'd3; mem[45] = 16'd9; mem[46] = 16'h0103; mem[47] = 16'h0205;
      for (int i = 0; i < 3; i++) begin
         mem[8 + 3*i]  = ins(5, 40);
         mem[9 + 3*i]  = ins(2, 41 + i);
         mem[10 + 3*i] = ins(6, 50 + i);
      end
      mem[17] = ins(5, 44); mem[18] = ins(3, 45); mem[19] = ins(6, 53);
      mem[20] = ins(5, 46); mem[21] = ins(7, 47); mem[22] = ins(6, 54);
      run("alu", 17, -1);
      check("shr4", 32'(mem[50]), 32'h000F);
      check("shl4", 32'(mem[51]), 32'h0F00);
      check("sh40", 32'(mem[52]), 0);
      check("lt", 32'(mem[53]), 1);
`ifdef ACCUM_CPU_MUL_EN
      check("mul", 32'(mem[54]), 32'h000F);
`else
      check("mul", 32'(mem[54]), 32'h0103);
`endif

      // BZ self-branch at pc 6 -> halt.
      clear_mem();
      mem[60] = 16'h0; mem[61] = 16'd6; mem[62] = 16'd1;
      mem[0] = ins(5, 60);
      for (int i = 1; i < 6; i++) mem[i] = ins(0, 60);
      mem[6] = ins(4, 61);
      run("halt", 7, 0);
      check("halt_flag", 32'(halted), 1);
      check("halt_pc", 32'(pCounter), 6);
      any_req = 0;
      repeat (5) begin
         @(negedge clk);
         if (mem_req) any_req = 1;
      end
      check("halt_noreq", any_req, 0);

      // Same BZ with W=1 falls through.
      mem[0] = ins(5, 62);
      run("bznt", 7, 0);
      check("bznt_pc", 32'(pCounter), 7);

      // Random programs.
      for (int r = 0; r < 3; r++) begin
         clear_mem(); prologue();
         mem[IND] = 16'($urandom_range(64, 127));
         for (int i = 64; i < 128; i++)
            mem[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 40))
                                                 : 16'($urandom_range(0, 65535));
         for (int i = 8; i < 28; i++)
            mem[i] = ins(ops[$urandom_range(0, 6)],
                         ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(64, 127)));
         mem[28] = ins(6, 62);
         run("rand", 23, (r == 1) ? -1 : r * 2);
         n_mis = 0;
         for (int i = 62; i < 128; i++) if (mem[i] !== ref_mem[i]) n_mis++;
         check("rand_mem", n_mis, 0);
         check("rand_w", 32'(mem[62]), exp_w);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
